// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator. Channels share one period counter that runs in
// edge- or center-aligned mode. Shadow settings are copied to the active set only at a cycle boundary.
module pwm_multichannel #(
  parameter int CHANNELS = 16,
  parameter int CNT_W    = 8,
  parameter int PRESC_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en_out,
  input  logic [CHANNELS-1:0]       en_pwm,
  input  logic [CHANNELS-1:0]       invert,
  input  logic [CHANNELS*CNT_W-1:0] duty_in,
  input  logic [CNT_W-1:0]          period_in,
  input  logic [PRESC_W-1:0]        prescale_in,
  input  logic                      center_in,
  input  logic                      update_req,
  output logic [CHANNELS-1:0]       out,
  output logic                      period_done,
  output logic                      update_pending
);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dir_down_q, dir_down_d;
  logic                pend_q, pend_d;
  logic [CNT_W-1:0]    period_act_q;
  logic [PRESC_W-1:0]  presc_act_q;
  logic                center_act_q;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                done_q;
  logic                tick;
  logic                boundary;
  logic                load;

  assign tick = (presc_q == presc_act_q);

  always_comb begin
    presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    boundary   = 1'b0;
    if (tick) begin
      if (period_act_q == '0) begin
        cnt_d    = '0;
        boundary = 1'b1;
      end else if (!center_act_q) begin
        if (cnt_q == period_act_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (!dir_down_q) begin
        // Top endpoint is visited once: turn around and step down on the same tick.
        if (cnt_q == period_act_q) begin
          cnt_d      = cnt_q - CNT_W'(1);
          dir_down_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d      = CNT_W'(1);
          dir_down_d = 1'b0;
          boundary   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
    load = boundary & (pend_q | update_req);
    if (load) begin
      presc_d    = '0;
      cnt_d      = '0;
      dir_down_d = 1'b0;
    end
    pend_d = load ? 1'b0 : (pend_q | update_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      cnt_q        <= '0;
      dir_down_q   <= 1'b0;
      pend_q       <= 1'b0;
      period_act_q <= '1;
      presc_act_q  <= '0;
      center_act_q <= 1'b0;
      out_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
      done_q     <= boundary;
      if (load) begin
        period_act_q <= period_in;
        presc_act_q  <= prescale_in;
        center_act_q <= center_in;
      end
    end
  end

  // Per-channel active duty and output shaping; enables bypass the shadow path.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : ch_g
    logic [CNT_W-1:0] duty_q;
    logic             raw;

    always_ff @(posedge clk) begin
      if (rst) begin
        duty_q <= '0;
      end else if (load) begin
        duty_q <= duty_in[gi*CNT_W +: CNT_W];
      end
    end

    assign raw       = (cnt_q < duty_q);
    assign out_d[gi] = en_out[gi] & (en_pwm[gi] ? (raw ^ invert[gi]) : 1'b1);
  end

  assign out            = out_q;
  assign period_done    = done_q;
  assign update_pending = pend_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: cycle-by-cycle reference model from the counting rules,
// a static-output vector table, directed multi-cycle scenarios and a randomized run.
module tb_pwm_multichannel;
  localparam int CH = 16;
  localparam int CW = 8;
  localparam int PW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     en_out, en_pwm, invert;
  logic [CH*CW-1:0]  duty_in;
  logic [CW-1:0]     period_in;
  logic [PW-1:0]     prescale_in;
  logic              center_in, update_req;
  logic [CH-1:0]     out;
  logic              period_done, update_pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_multichannel #(.CHANNELS(CH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .en_out(en_out), .en_pwm(en_pwm), .invert(invert),
    .duty_in(duty_in), .period_in(period_in), .prescale_in(prescale_in),
    .center_in(center_in), .update_req(update_req), .out(out),
    .period_done(period_done), .update_pending(update_pending)
  );

  // Reference model: c counts clocks since the last load; everything else is arithmetic on c.
  int            m_c = 0;
  int            m_p = 255;
  int            m_s = 0;
  bit            m_ctr = 1'b0;
  int            m_duty [CH];
  bit            m_pend = 1'b0;
  logic [CH-1:0] e_out;
  logic          e_done;

  function automatic int cnt_of(input int c, input int p, input int s, input bit ctr);
    int k, m;
    k = c / (s + 1);
    if (p == 0) return 0;
    if (!ctr) return k % (p + 1);
    m = k % (2 * p);
    return (m <= p) ? m : 2 * p - m;
  endfunction

  function automatic bit bnd_of(input int c, input int p, input int s, input bit ctr);
    int k;
    if ((c % (s + 1)) != s) return 1'b0;
    k = c / (s + 1);
    if (p == 0) return 1'b1;
    if (!ctr) return (k % (p + 1)) == p;
    return ((k % (2 * p)) == 0) && (k > 0);
  endfunction

  function automatic logic [CH-1:0] model_out(input logic [CH-1:0] eo, input logic [CH-1:0] ep,
                                              input logic [CH-1:0] inv, input int cnt);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) begin
      r[i] = eo[i] & (ep[i] ? ((cnt < m_duty[i]) ^ inv[i]) : 1'b1);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_c    <= 0;
      m_p    <= 255;
      m_s    <= 0;
      m_ctr  <= 1'b0;
      m_pend <= 1'b0;
      e_out  <= '0;
      e_done <= 1'b0;
      for (int i = 0; i < CH; i++) m_duty[i] <= 0;
    end else begin
      e_out  <= model_out(en_out, en_pwm, invert, cnt_of(m_c, m_p, m_s, m_ctr));
      e_done <= bnd_of(m_c, m_p, m_s, m_ctr);
      if (bnd_of(m_c, m_p, m_s, m_ctr) && (m_pend || update_req)) begin
        m_c    <= 0;
        m_p    <= int'(period_in);
        m_s    <= int'(prescale_in);
        m_ctr  <= center_in;
        m_pend <= 1'b0;
        for (int i = 0; i < CH; i++) m_duty[i] <= int'(duty_in[i*CW +: CW]);
      end else begin
        m_c    <= m_c + 1;
        m_pend <= m_pend | update_req;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    check("mon_out", 32'(out), 32'(e_out));
    check("mon_done", 32'(period_done), 32'(e_done));
    check("mon_pend", 32'(update_pending), 32'(m_pend));
  end

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_done !== 1'b1 && n < limit);
    if (period_done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL timeout: no period_done within %0d clocks at %0t", limit, $time);
    end
  endtask

  task automatic pulse_req();
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
  endtask

  task automatic set_duty(input int ch, input int val);
    duty_in[ch*CW +: CW] = CW'(val);
  endtask

  task automatic count_bits(input int ncyc, input int b, output int hi, output int dn);
    hi = 0;
    dn = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      hi += int'(out[b]);
      dn += int'(period_done);
    end
  endtask

  typedef struct {
    logic [CH-1:0] eo;
    logic [CH-1:0] ep;
    logic [CH-1:0] inv;
    logic [CH-1:0] exp;
  } vec_t;
  vec_t vt [8];

  initial begin
    int n, hi, dn, hi1;
    // Raw PWM is 16'hFF00 here: channels 0-7 have duty 0, channels 8-15 duty 200 > period.
    vt[0] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'hFF00};
    vt[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF};
    vt[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    vt[3] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    vt[4] = '{16'h00F0, 16'hFFFF, 16'h0000, 16'h0000};
    vt[5] = '{16'hF0F0, 16'h0F0F, 16'h0000, 16'hF0F0};
    vt[6] = '{16'hFFFF, 16'hFFFF, 16'h0F0F, 16'hF00F};
    vt[7] = '{16'hFFFF, 16'h00FF, 16'hFFFF, 16'hFFFF};

    rst = 1'b1;
    en_out = '1;
    en_pwm = '1;
    invert = '0;
    duty_in = '0;
    period_in = '0;
    prescale_in = '0;
    center_in = 1'b0;
    update_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out), 32'h0);
    check("rst_done", 32'(period_done), 32'h0);
    check("rst_pend", 32'(update_pending), 32'h0);
    $display("txn reset: out=%h done=%b pend=%b", out, period_done, update_pending);
    rst = 1'b0;

    // Edge mode, period 9, duty 3; the first load waits out the 256-clock reset period.
    period_in = 8'd9;
    set_duty(0, 3);
    pulse_req();
    check("pend_armed", 32'(update_pending), 32'h1);
    wait_done(300, n);
    check("load_latency", 32'(n), 32'd255);
    wait_done(30, n);
    check("edge_interval", 32'(n), 32'd10);
    count_bits(10, 0, hi, dn);
    check("edge_high", 32'(hi), 32'd3);
    check("edge_done_cnt", 32'(dn), 32'd1);
    $display("txn edge: interval=%0d high=%0d", n, hi);

    // Duty boundaries and immediate polarity change.
    set_duty(0, 0);
    set_duty(1, 15);
    pulse_req();
    wait_done(30, n);
    wait_done(30, n);
    hi = 0;
    hi1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hi += int'(out[0]);
      hi1 += int'(out[1]);
    end
    check("duty0_low", 32'(hi), 32'd0);
    check("duty_over_high", 32'(hi1), 32'd20);
    invert[1] = 1'b1;
    @(negedge clk);
    check("invert_now", 32'(out[1]), 32'h0);
    invert = '0;
    $display("txn duty_bounds: ch0_high=%0d ch1_high=%0d", hi, hi1);

    // Static vector table over enables and polarity.
    for (int i = 0; i < CH; i++) set_duty(i, (i < 8) ? 0 : 200);
    pulse_req();
    wait_done(30, n);
    wait_done(30, n);
    for (int i = 0; i < 8; i++) begin
      en_out = vt[i].eo;
      en_pwm = vt[i].ep;
      invert = vt[i].inv;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(out), 32'(vt[i].exp));
      $display("txn vec%0d: en_out=%h en_pwm=%h invert=%h out=%h", i, vt[i].eo, vt[i].ep, vt[i].inv, out);
    end
    en_out = '1;
    en_pwm = '1;
    invert = '0;

    // Center-aligned, period 4, duty 2.
    for (int i = 0; i < CH; i++) set_duty(i, 0);
    set_duty(0, 2);
    period_in = 8'd4;
    center_in = 1'b1;
    pulse_req();
    wait_done(30, n);
    wait_done(30, n);
    wait_done(30, n);
    check("center_interval", 32'(n), 32'd8);
    $display("txn center: interval=%0d", n);

    // Prescaled edge mode, prescale 2, period 3, duty 1.
    center_in = 1'b0;
    period_in = 8'd3;
    prescale_in = 8'd2;
    set_duty(0, 1);
    pulse_req();
    wait_done(60, n);
    wait_done(60, n);
    wait_done(60, n);
    check("presc_interval", 32'(n), 32'd12);
    count_bits(12, 0, hi, dn);
    check("presc_high", 32'(hi), 32'd3);
    check("presc_done_cnt", 32'(dn), 32'd1);
    $display("txn prescale: interval=%0d high=%0d", n, hi);

    // Mid-cycle request lets the current cycle finish; a request on the boundary loads at once.
    prescale_in = 8'd0;
    period_in = 8'd9;
    set_duty(0, 3);
    pulse_req();
    wait_done(60, n);
    wait_done(60, n);
    repeat (3) @(negedge clk);
    period_in = 8'd4;
    pulse_req();
    check("midreq_pend", 32'(update_pending), 32'h1);
    wait_done(30, n);
    check("old_cycle_len", 32'(n + 4), 32'd10);
    check("pend_cleared", 32'(update_pending), 32'h0);
    wait_done(30, n);
    check("new_interval", 32'(n), 32'd5);
    repeat (4) @(negedge clk);
    period_in = 8'd6;
    pulse_req();
    check("coincide_done", 32'(period_done), 32'h1);
    check("coincide_pend", 32'(update_pending), 32'h0);
    wait_done(30, n);
    check("coincide_interval", 32'(n), 32'd7);
    $display("txn update_timing: interval=%0d", n);

    // Reset mid-cycle discards an armed update.
    repeat (2) @(negedge clk);
    period_in = 8'd2;
    pulse_req();
    check("pre_rst_pend", 32'(update_pending), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_done", 32'(period_done), 32'h0);
    check("midrst_pend", 32'(update_pending), 32'h0);
    rst = 1'b0;
    wait_done(300, n);
    check("rst_period", 32'(n), 32'd256);
    $display("txn mid_reset: first boundary after %0d clocks", n);

    // Randomized run against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 15) == 0) begin
        en_out = CH'($urandom);
        en_pwm = CH'($urandom);
        invert = CH'($urandom);
      end
      for (int i = 0; i < CH; i++) set_duty(i, int'($urandom_range(0, 15)));
      period_in = CW'($urandom_range(0, 12));
      prescale_in = PW'($urandom_range(0, 3));
      center_in = 1'($urandom_range(0, 1));
      update_req = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    update_req = 1'b0;
    @(negedge clk);
    $display("txn random: 3000 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
